bcd_seg_scan: RTL and testbench

Downstream consumer of the 8-bit binary-to-BCD converter. Captures its 10-bit packed BCD result (hundreds[9:8], tens[7:4], ones[3:0]) into a holding register. Drives a 3-digit time-multiplexed 7-segment display with per-digit dwell, optional leading-zero blanking and a frame-complete pulse. Sits between the converter and the board display pins.

---
 rtl/bcd_seg_scan.sv | 197 +++++++++++++++++++
 tb/tb_bcd_seg_scan.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bcd_seg_scan
// Description : Captures a packed 3-digit BCD value (hundreds[9:8],
//               tens[7:4], ones[3:0]) and scans it onto a time-multiplexed
//               3-digit common 7-segment display. Supports per-digit dwell
//               time, optional leading-zero blanking and a frame-complete
//               pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg_scan #(
    parameter int SCAN_DIV = 4      // cycles per digit, legal range 2..65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] bcd_in,
    input  logic       bcd_load,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [2:0] dig_en,
    output logic       frame_done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int            PW          = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] C_PRESC_MAX = PW'(SCAN_DIV - 1);

    // Digit-index states; 2'd3 is unreachable and recovers to ones.
    localparam logic [1:0] C_S_ONES = 2'd0;
    localparam logic [1:0] C_S_TENS = 2'd1;
    localparam logic [1:0] C_S_HUND = 2'd2;

    // Segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] C_SEG_DASH  = 7'h40;
    localparam logic [6:0] C_SEG_BLANK = 7'h00;

    localparam logic [2:0] C_DIG_ONES = 3'b001;
    localparam logic [2:0] C_DIG_TENS = 3'b010;
    localparam logic [2:0] C_DIG_HUND = 3'b100;
    localparam logic [2:0] C_DIG_NONE = 3'b000;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [9:0]    hold_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          w_presc_wrap;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [6:0]    seg_q;
    logic [6:0]    seg_d;
    logic [2:0]    dig_en_q;
    logic [2:0]    dig_en_d;
    logic          frame_done_q;
    logic          frame_done_d;

    logic [1:0]    w_hund;
    logic [3:0]    w_tens;
    logic [3:0]    w_ones;
    logic          w_blank_hund;
    logic          w_blank_tens;

    // BCD digit to segment pattern; non-decimal codes show a dash.
    function automatic logic [6:0] f_decode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = C_SEG_DASH;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------------
    // Holding register: captures the converter result on a load strobe.
    // A load never touches the scan timing.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (bcd_load) begin
            hold_q <= bcd_in;
        end
    end

    assign w_hund = hold_q[9:8];
    assign w_tens = hold_q[7:4];
    assign w_ones = hold_q[3:0];

    // ------------------------------------------------------------------------
    // Dwell prescaler: counts 0..SCAN_DIV-1 and wraps.
    // ------------------------------------------------------------------------
    always_comb begin
        w_presc_wrap = (presc_q == C_PRESC_MAX);
        presc_d      = w_presc_wrap ? '0 : presc_q + 1'b1;
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------------
    // Digit-index state machine (ones -> tens -> hundreds -> ones)
    // ------------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_S_ONES;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: advance only when the current digit's dwell has expired.
    always_comb begin
        state_d = state_q;
        if (w_presc_wrap) begin
            case (state_q)
                C_S_ONES: state_d = C_S_TENS;
                C_S_TENS: state_d = C_S_HUND;
                default:  state_d = C_S_ONES;
            endcase
        end
    end

    // Output decode from the pre-edge index: digit select, blanking, pattern
    // and frame pulse. The ones digit is never blanked so a value of zero
    // still shows a single "0".
    always_comb begin
        w_blank_hund = blank_lz && (w_hund == 2'd0);
        w_blank_tens = blank_lz && (w_hund == 2'd0) && (w_tens == 4'd0);
        seg_d        = C_SEG_BLANK;
        dig_en_d     = C_DIG_NONE;
        frame_done_d = w_presc_wrap && (state_q == C_S_HUND);
        case (state_q)
            C_S_ONES: begin
                seg_d    = f_decode(w_ones);
                dig_en_d = C_DIG_ONES;
            end
            C_S_TENS: begin
                if (!w_blank_tens) begin
                    seg_d    = f_decode(w_tens);
                    dig_en_d = C_DIG_TENS;
                end
            end
            C_S_HUND: begin
                if (!w_blank_hund) begin
                    seg_d    = f_decode({2'b00, w_hund});
                    dig_en_d = C_DIG_HUND;
                end
            end
            default: begin
                seg_d    = C_SEG_BLANK;
                dig_en_d = C_DIG_NONE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered display outputs; they trail the digit index by one cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= '0;
            dig_en_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bcd_seg_scan
// Description : Scoreboard bench for bcd_seg_scan. The driver pushes the
//               expected display state for every edge; a monitor pops and
//               compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_seg_scan;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 3 * SCAN_DIV;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [9:0] bcd_in   = '0;
    logic       bcd_load = 1'b0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [2:0] dig_en;
    logic       frame_done;

    bcd_seg_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .bcd_load   (bcd_load),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [2:0] den;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Segment table {g,f,e,d,c,b,a} for decimal digits 0..9.
    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model state: held digits and edges elapsed since reset.
    bit m_started = 0;
    int m_t       = 0;
    int m_h       = 0;
    int m_tn      = 0;
    int m_o       = 0;

    function automatic logic [6:0] ref_seg(input int d);
        if (d <= 9) return seg_tbl[d];
        return 7'h40;
    endfunction

    // Predict what the DUT shows after the coming edge, given the inputs now
    // on the pins, then apply that edge's effect to the model state.
    task automatic model_step();
        exp_t e;
        int   slot;
        bit   blank;
        if (rst) begin
            m_started = 1;
            m_t  = 0;
            m_h  = 0;
            m_tn = 0;
            m_o  = 0;
            e.seg = 7'h00; e.den = 3'b000; e.fd = 1'b0;
            exp_q.push_back(e);
        end else if (m_started) begin
            m_t   = m_t + 1;
            slot  = ((m_t - 1) / SCAN_DIV) % 3;
            e.fd  = ((m_t % FRAME) == 0);
            blank = 0;
            if (slot == 0) begin
                e.seg = ref_seg(m_o);  e.den = 3'b001;
            end else if (slot == 1) begin
                blank = blank_lz && (m_h == 0) && (m_tn == 0);
                e.seg = ref_seg(m_tn); e.den = 3'b010;
            end else begin
                blank = blank_lz && (m_h == 0);
                e.seg = ref_seg(m_h);  e.den = 3'b100;
            end
            if (blank) begin
                e.seg = 7'h00; e.den = 3'b000;
            end
            exp_q.push_back(e);
            if (bcd_load) begin
                m_h  = int'(bcd_in[9:8]);
                m_tn = int'(bcd_in[7:4]);
                m_o  = int'(bcd_in[3:0]);
            end
        end
    endtask

    task automatic cyc(input logic r, input logic ld, input logic [9:0] d, input logic bl);
        rst      = r;
        bcd_load = ld;
        bcd_in   = d;
        blank_lz = bl;
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic bl);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, $urandom_range(0, 1023), bl);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("seg",        {1'b0, seg},        {1'b0, e.seg});
                chk("dig_en",     {5'b0, dig_en},     {5'b0, e.den});
                chk("frame_done", {7'b0, frame_done}, {7'b0, e.fd});
            end
        end
    end

    // Driver
    initial begin
        int wait_cnt;
        logic r, ld, bl;
        logic [9:0] d;

        cyc(1'b1, 1'b0, 10'h000, 1'b0);
        cyc(1'b1, 1'b0, 10'h000, 1'b0);

        // 255 shown unblanked across several frames
        cyc(1'b0, 1'b1, 10'b10_0101_0101, 1'b0);
        idle(3 * FRAME, 1'b0);

        // zero with blanking: only the ones digit lit
        cyc(1'b0, 1'b1, 10'b00_0000_0000, 1'b1);
        idle(2 * FRAME, 1'b1);

        // 5 then 100 with blanking
        cyc(1'b0, 1'b1, 10'b00_0000_0101, 1'b1);
        idle(FRAME, 1'b1);
        cyc(1'b0, 1'b1, 10'b01_0000_0000, 1'b1);
        idle(FRAME, 1'b1);

        // invalid ones nibble shows a dash
        cyc(1'b0, 1'b1, 10'b00_0001_1100, 1'b0);
        idle(FRAME, 1'b0);

        // load 199 in the middle of the tens slot right after a fresh reset
        cyc(1'b1, 1'b0, 10'h000, 1'b0);
        idle(5, 1'b0);
        cyc(1'b0, 1'b1, 10'b01_1001_1001, 1'b0);
        idle(FRAME, 1'b0);

        // reset mid-hundreds slot with a simultaneous load
        wait_cnt = 0;
        while (!((((m_t / SCAN_DIV) % 3) == 2) && ((m_t % SCAN_DIV) == 1)) && wait_cnt < 4 * FRAME) begin
            idle(1, 1'b0);
            wait_cnt++;
        end
        cyc(1'b1, 1'b1, 10'b11_1111_1111, 1'b0);
        idle(2 * FRAME, 1'b0);

        // blank_lz toggled mid-scan on a value with zero hundreds and tens
        cyc(1'b0, 1'b1, 10'b00_0000_0111, 1'b0);
        for (int i = 0; i < 2 * FRAME; i++) cyc(1'b0, 1'b0, 10'h000, logic'(i[2]));

        // randomized traffic
        bl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 149) == 0);
            ld = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 3) == 0) d = 10'($urandom_range(0, 1023));
            else d = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 2) == 0 && ld) d[7:0] = 8'h00;
            if ($urandom_range(0, 40) == 0) bl = ~bl;
            cyc(r, ld, d, bl);
        end

        // drain the scoreboard with a bounded wait
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        n_cmp = n_cmp + 1;
        if (exp_q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
